// File: rtl/sisc_ctrl_mc_pkg.sv
// Shared types and constants for the SISC multi-cycle controller.
package sisc_pkg;

  typedef enum logic [2:0] {
    S_START0,
    S_START1,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  localparam int AM_IMM = 8;

  localparam logic [1:0] ALU_REG  = 2'b00;
  localparam logic [1:0] ALU_IMM  = 2'b01;
  localparam logic [1:0] ALU_ADDR = 2'b10;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOD) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/sisc_ctrl_mc_if.sv
// Bus between the SISC datapath (master side) and its multi-cycle controller (slave side).
interface sisc_ctrl_mc_if #(
  parameter int STAT_W = 4
);
  logic [3:0]        opcode;
  logic [STAT_W-1:0] mm;
  logic [STAT_W-1:0] stat;
  logic              mem_ready;

  logic              ir_load;
  logic              pc_write;
  logic              pc_sel;
  logic              br_sel;
  logic              rd_sel;
  logic              rf_we;
  logic              wb_sel;
  logic              stat_en;
  logic              dm_we;
  logic [1:0]        alu_op;
  logic              halted;
  logic              mem_err;

  modport master (
    output opcode, mm, stat, mem_ready,
    input  ir_load, pc_write, pc_sel, br_sel, rd_sel, rf_we, wb_sel,
           stat_en, dm_we, alu_op, halted, mem_err
  );

  modport slave (
    input  opcode, mm, stat, mem_ready,
    output ir_load, pc_write, pc_sel, br_sel, rd_sel, rf_we, wb_sel,
           stat_en, dm_we, alu_op, halted, mem_err
  );
endinterface

// File: rtl/sisc_br_eval.sv
// Branch-condition evaluation: taken flag and absolute/relative select.
module sisc_br_eval
  import sisc_pkg::*;
#(
  parameter int STAT_W = 4
) (
  input  logic [3:0]        opcode_i,
  input  logic [STAT_W-1:0] mm_i,
  input  logic [STAT_W-1:0] stat_i,
  output logic              taken_o,
  output logic              br_sel_o
);

  logic hit;
  assign hit = |(mm_i & stat_i);

  // BRA/BRR branch when a masked flag is set, BNE when none is.
  always_comb begin
    taken_o = 1'b0;
    if ((opcode_i == OP_BRA) || (opcode_i == OP_BRR)) taken_o = hit;
    else if (opcode_i == OP_BNE)                       taken_o = !hit;
  end

  assign br_sel_o = (opcode_i == OP_BRR) || (opcode_i == OP_BNE);

endmodule

// File: rtl/sisc_ctrl_mc.sv
// SISC multi-cycle control FSM. Optional memory wait/timeout: define SISC_CTRL_MEMWAIT_EN.
module sisc_ctrl_mc
  import sisc_pkg::*;
#(
  parameter int STAT_W       = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic          clk,
  input  logic          rst_f,
  sisc_ctrl_mc_if.slave bus
);

  if ((MEM_WAIT_MAX < 1) || (MEM_WAIT_MAX > 255)) begin : g_bad_wait_max
    $error("MEM_WAIT_MAX must be in 1..255");
  end

  state_t state_q, state_d;
  logic   run_q;
  logic   taken, br_rel;
  logic   mem_done, mem_timeout, mem_err;

  sisc_br_eval #(.STAT_W(STAT_W)) u_br_eval (
    .opcode_i (bus.opcode),
    .mm_i     (bus.mm),
    .stat_i   (bus.stat),
    .taken_o  (taken),
    .br_sel_o (br_rel)
  );

`ifdef SISC_CTRL_MEMWAIT_EN
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  logic [7:0] wcnt_q, wcnt_d;
  logic       mem_err_q;

  // Ready on the limit cycle still exits normally; timeout only fires without it.
  always_comb begin
    mem_done    = 1'b1;
    mem_timeout = 1'b0;
    if (is_mem_op(bus.opcode) && !bus.mem_ready) begin
      mem_done    = 1'b0;
      mem_timeout = (wcnt_q == WAIT_LAST);
    end
    wcnt_d = 8'd0;
    if ((state_q == S_MEM) && !mem_done && !mem_timeout) wcnt_d = wcnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      wcnt_q    <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      if ((state_q == S_MEM) && mem_timeout) mem_err_q <= 1'b1;
    end
  end

  assign mem_err = mem_err_q;
`else
  assign mem_done    = 1'b1;
  assign mem_timeout = 1'b0;
  assign mem_err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START0:    state_d = S_START1;
      S_START1:    state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = (bus.opcode == OP_HLT) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_d = S_MEM;
      S_MEM:       state_d = mem_timeout ? S_HALT : (mem_done ? S_WRITEBACK : S_MEM);
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_START0;
    endcase
  end

  // The first edge after reset release re-enters START0 before the sequence advances.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= S_START0;
      run_q   <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= run_q ? state_d : S_START0;
    end
  end

  logic       ir_load, pc_write, pc_sel, br_sel, rd_sel;
  logic       rf_we, wb_sel, stat_en, dm_we, halted;
  logic [1:0] alu_op;

  always_comb begin
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    rd_sel   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    stat_en  = 1'b0;
    dm_we    = 1'b0;
    alu_op   = ALU_REG;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        rd_sel = (bus.opcode == OP_STR);
        if (taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = br_rel;
        end
      end
      S_EXECUTE: begin
        rd_sel = (bus.opcode == OP_STR);
        if (bus.opcode == OP_ALU) begin
          stat_en = 1'b1;
          alu_op  = (bus.mm == STAT_W'(AM_IMM)) ? ALU_IMM : ALU_REG;
        end else if (is_mem_op(bus.opcode)) begin
          alu_op = ALU_ADDR;
        end
      end
      S_MEM: begin
        rd_sel = (bus.opcode == OP_STR);
        dm_we  = (bus.opcode == OP_STR);
      end
      S_WRITEBACK: begin
        rf_we  = (bus.opcode == OP_LOD) || (bus.opcode == OP_ALU);
        wb_sel = (bus.opcode == OP_LOD);
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.ir_load  = ir_load;
  assign bus.pc_write = pc_write;
  assign bus.pc_sel   = pc_sel;
  assign bus.br_sel   = br_sel;
  assign bus.rd_sel   = rd_sel;
  assign bus.rf_we    = rf_we;
  assign bus.wb_sel   = wb_sel;
  assign bus.stat_en  = stat_en;
  assign bus.dm_we    = dm_we;
  assign bus.alu_op   = alu_op;
  assign bus.halted   = halted;
  assign bus.mem_err  = mem_err;

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Bench for sisc_ctrl_mc: per-instruction expected strobe sequences from an opcode-level model.
module tb_sisc_ctrl_mc;

  localparam int WMAX = 4;
`ifdef SISC_CTRL_MEMWAIT_EN
  localparam bit MW = 1'b1;
`else
  localparam bit MW = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_f = 1'b1;
  always #5 clk = ~clk;

  sisc_ctrl_mc_if #(.STAT_W(4)) bus ();

  sisc_ctrl_mc #(.STAT_W(4), .MEM_WAIT_MAX(WMAX)) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  // {ir_load,pc_write,pc_sel,br_sel,rd_sel,rf_we,wb_sel,stat_en,dm_we,alu_op[1:0],halted,mem_err}
  typedef logic [12:0] vec_t;
  typedef struct {
    logic [3:0] op;
    logic [3:0] mm;
    logic [3:0] st;
    logic       rdy;
  } stim_t;

  vec_t got_w;
  assign got_w = {bus.ir_load, bus.pc_write, bus.pc_sel, bus.br_sel, bus.rd_sel,
                  bus.rf_we, bus.wb_sel, bus.stat_en, bus.dm_we, bus.alu_op,
                  bus.halted, bus.mem_err};

  stim_t stim_q[$];
  vec_t  exp_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  function automatic vec_t mk(bit ir, bit pw, bit ps, bit bs, bit rd, bit we, bit wb,
                              bit se, bit dw, logic [1:0] alu, bit h, bit e);
    return {ir, pw, ps, bs, rd, we, wb, se, dw, alu, h, e};
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.op  = 4'($urandom);
    s.mm  = 4'($urandom);
    s.st  = 4'($urandom);
    s.rdy = 1'($urandom);
    return s;
  endfunction

  function automatic void push(stim_t s, vec_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endfunction

  function automatic void model_start();
    push(rnd_stim(), '0);
    push(rnd_stim(), '0);
  endfunction

  // rdy_at: MEM cycle (1-based) where mem_ready rises; outside 1..WMAX means never.
  function automatic void model_instr(logic [3:0] op, logic [3:0] mm, logic [3:0] st,
                                      int rdy_at, int n_halt);
    stim_t      s;
    bit         tk, tmo;
    logic [1:0] alu;
    int         nmem;
    push(rnd_stim(), mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    s    = rnd_stim();
    s.op = op;
    s.mm = mm;
    s.st = st;
    tk = (((op == 4) || (op == 5)) && ((mm & st) != 0)) || ((op == 6) && ((mm & st) == 0));
    push(s, mk(0, tk, tk, tk && (op != 4), op == 2, 0, 0, 0, 0, 2'b00, 0, 0));
    if (op == 15) begin
      for (int i = 0; i < n_halt; i++) push(rnd_stim(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
      return;
    end
    alu = 2'b00;
    if (op == 8) alu = (mm == 8) ? 2'b01 : 2'b00;
    else if ((op == 1) || (op == 2)) alu = 2'b10;
    s.rdy = 1'($urandom);
    push(s, mk(0, 0, 0, 0, op == 2, 0, 0, op == 8, 0, alu, 0, 0));
    if (MW && ((op == 1) || (op == 2))) begin
      tmo  = (rdy_at < 1) || (rdy_at > WMAX);
      nmem = tmo ? WMAX : rdy_at;
      for (int i = 1; i <= nmem; i++) begin
        s.rdy = (i == rdy_at);
        push(s, mk(0, 0, 0, 0, op == 2, 0, 0, 0, op == 2, 2'b00, 0, 0));
      end
      if (tmo) begin
        for (int i = 0; i < n_halt; i++) push(s, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1));
        return;
      end
    end else begin
      s.rdy = 1'($urandom);
      push(s, mk(0, 0, 0, 0, op == 2, 0, 0, 0, op == 2, 2'b00, 0, 0));
    end
    s.rdy = 1'($urandom);
    push(s, mk(0, 0, 0, 0, 0, (op == 1) || (op == 8), op == 1, 0, 0, 2'b00, 0, 0));
  endfunction

  task automatic step(input stim_t s, output vec_t got);
    @(posedge clk);
    #1;
    bus.opcode    = s.op;
    bus.mm        = s.mm;
    bus.stat      = s.st;
    bus.mem_ready = s.rdy;
    @(negedge clk);
    got = got_w;
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1 rst_f = 1'b1;
  endtask

  task automatic test_reset();
    stim_t s;
    vec_t  e, got;
    bus.opcode = 4'd0; bus.mm = 4'd0; bus.stat = 4'd0; bus.mem_ready = 1'b0;
    #2 rst_f = 1'b0;
    #2;
    n_chk++;
    if (got_w !== '0) $display("FAIL reset_async got=%b exp=%b", got_w, 13'b0);
    else n_pass++;
    reset_release();
    model_start();
    for (int i = 0; i < 3; i++) model_instr(4'd0, 4'($urandom), 4'($urandom), 1, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      step(s, got); n_chk++;
      if (got !== e) $display("FAIL reset_seq chk=%0d got=%b exp=%b", n_chk, got, e);
      else n_pass++;
    end
  endtask

  task automatic test_alu();
    stim_t s;
    vec_t  e, got;
    model_instr(4'd8, 4'd8, 4'($urandom), 1, 0);
    model_instr(4'd8, 4'd3, 4'($urandom), 1, 0);
    model_instr(4'd8, 4'd0, 4'($urandom), 1, 0);
    model_instr(4'd1, 4'($urandom), 4'($urandom), 1, 0);
    model_instr(4'd2, 4'($urandom), 4'($urandom), 1, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      step(s, got); n_chk++;
      if (got !== e) $display("FAIL alu_ops chk=%0d op=%0d got=%b exp=%b", n_chk, s.op, got, e);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    stim_t s;
    vec_t  e, got;
    model_instr(4'd5, 4'b0010, 4'b0010, 1, 0);
    model_instr(4'd5, 4'b0010, 4'b0000, 1, 0);
    model_instr(4'd4, 4'b1100, 4'b0100, 1, 0);
    model_instr(4'd4, 4'b1100, 4'b0011, 1, 0);
    model_instr(4'd6, 4'b0001, 4'b0000, 1, 0);
    model_instr(4'd6, 4'b0001, 4'b1111, 1, 0);
    model_instr(4'd6, 4'b0000, 4'b1111, 1, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      step(s, got); n_chk++;
      if (got !== e) $display("FAIL branch chk=%0d op=%0d got=%b exp=%b", n_chk, s.op, got, e);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    stim_t s;
    vec_t  e, got;
    for (int i = 0; i < 30; i++)
      model_instr(4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom),
                  int'($urandom_range(1, WMAX)), 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      step(s, got); n_chk++;
      if (got !== e) $display("FAIL random chk=%0d op=%0d got=%b exp=%b", n_chk, s.op, got, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    stim_t s;
    vec_t  e, got;
    model_instr(4'd2, 4'($urandom), 4'($urandom), 0, 0);
    for (int i = 0; i < 4; i++) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      step(s, got); n_chk++;
      if (got !== e) $display("FAIL mid_pre chk=%0d got=%b exp=%b", n_chk, got, e);
      else n_pass++;
    end
    stim_q.delete(); exp_q.delete();
    rst_f = 1'b0;
    #1;
    n_chk++;
    if (got_w !== '0) $display("FAIL mid_reset got=%b exp=%b", got_w, 13'b0);
    else n_pass++;
    reset_release();
    model_start();
    model_instr(4'd1, 4'($urandom), 4'($urandom), 2, 0);
    model_instr(4'd0, 4'($urandom), 4'($urandom), 1, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      step(s, got); n_chk++;
      if (got !== e) $display("FAIL mid_restart chk=%0d got=%b exp=%b", n_chk, got, e);
      else n_pass++;
    end
  endtask

  task automatic test_memwait();
    stim_t s;
    vec_t  e, got;
    model_instr(4'd2, 4'($urandom), 4'($urandom), 3, 0);
    model_instr(4'd1, 4'($urandom), 4'($urandom), WMAX, 0);
    model_instr(4'd2, 4'($urandom), 4'($urandom), WMAX, 0);
    model_instr(4'd2, 4'($urandom), 4'($urandom), 0, 4);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      step(s, got); n_chk++;
      if (got !== e) $display("FAIL memwait chk=%0d got=%b exp=%b", n_chk, got, e);
      else n_pass++;
    end
    rst_f = 1'b0;
    #1;
    n_chk++;
    if (got_w !== '0) $display("FAIL memerr_clear got=%b exp=%b", got_w, 13'b0);
    else n_pass++;
    reset_release();
    model_start();
    model_instr(4'd8, 4'($urandom), 4'($urandom), 1, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      step(s, got); n_chk++;
      if (got !== e) $display("FAIL memwait_restart chk=%0d got=%b exp=%b", n_chk, got, e);
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    stim_t s;
    vec_t  e, got;
    model_instr(4'd15, 4'($urandom), 4'($urandom), 1, 20);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      step(s, got); n_chk++;
      if (got !== e) $display("FAIL halt chk=%0d got=%b exp=%b", n_chk, got, e);
      else n_pass++;
    end
    rst_f = 1'b0;
    #1;
    n_chk++;
    if (got_w !== '0) $display("FAIL halt_reset got=%b exp=%b", got_w, 13'b0);
    else n_pass++;
    reset_release();
    model_start();
    model_instr(4'd0, 4'($urandom), 4'($urandom), 1, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      step(s, got); n_chk++;
      if (got !== e) $display("FAIL halt_restart chk=%0d got=%b exp=%b", n_chk, got, e);
      else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired n_chk=%0d", n_chk);
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_random();
    test_reset_mid();
    if (MW) test_memwait();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
